// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: keeps a sticky bitmap of cover points hit by
// incoming hit beats, counts distinct covered points, and streams the bitmap
// out as 32-bit words on a valid/ready interface, optionally clearing it.
module cover_toggle_collector #(
    parameter int NUM_POINTS = 64,
    parameter int HIT_W      = 4,
    parameter int IDX_W      = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            hit_valid,
    input  logic [IDX_W-1:0]                hit_base,
    input  logic [HIT_W-1:0]                hit_bits,
    input  logic                            dump_req,
    input  logic                            dump_clear,
    output logic                            dump_valid,
    input  logic                            dump_ready,
    output logic [31:0]                     dump_data,
    output logic                            dump_last,
    output logic                            busy,
    output logic [$clog2(NUM_POINTS+1)-1:0] covered_count,
    output logic                            new_cover
);

    localparam int COUNT_W   = $clog2(NUM_POINTS + 1);
    localparam int NUM_WORDS = (NUM_POINTS + 31) / 32;
    localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [NUM_POINTS-1:0]    bitmap_r;
    logic [COUNT_W-1:0]       count_r;
    logic                     new_cover_r;
    logic [WORD_W-1:0]        word_idx_r;
    logic                     clear_r;

    logic [NUM_POINTS-1:0]    hit_mask_s;
    logic [NUM_POINTS-1:0]    new_bits_s;
    logic [NUM_WORDS*32-1:0]  padded_s;
    logic                     handshake_s;
    logic                     last_word_s;
    logic                     final_hs_s;

    // Population count of a point vector; used for both increments and reloads.
    function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_POINTS-1:0] v);
        logic [COUNT_W-1:0] cnt;
        cnt = {COUNT_W{1'b0}};
        for (int k = 0; k < NUM_POINTS; k++) begin
            cnt = cnt + COUNT_W'(v[k]);
        end
        return cnt;
    endfunction

    // Decode the hit beat into a point mask; out-of-range indices simply never match.
    always_comb begin
        logic [31:0] base_ext;
        hit_mask_s = {NUM_POINTS{1'b0}};
        base_ext   = 32'(hit_base);
        if (hit_valid) begin
            for (int j = 0; j < NUM_POINTS; j++) begin
                for (int i = 0; i < HIT_W; i++) begin
                    if (hit_bits[i] && ((base_ext + 32'(i)) == 32'(j))) begin
                        hit_mask_s[j] = 1'b1;
                    end else begin
                        hit_mask_s[j] = hit_mask_s[j];
                    end
                end
            end
        end else begin
            hit_mask_s = {NUM_POINTS{1'b0}};
        end
    end

    assign new_bits_s  = hit_mask_s & ~bitmap_r;
    assign handshake_s = (state_r == DUMP) && dump_ready;
    assign last_word_s = (word_idx_r == WORD_W'(NUM_WORDS - 1));
    assign final_hs_s  = handshake_s && last_word_s;

    // State register for the dump sequencer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: start on a request in IDLE, finish on the last accepted word.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (dump_req) begin
                    state_next_s = DUMP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DUMP: begin
                if (final_hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DUMP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Word pointer and latched clear flag for the dump in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_idx_r <= {WORD_W{1'b0}};
            clear_r    <= 1'b0;
        end else if (state_r == IDLE) begin
            word_idx_r <= {WORD_W{1'b0}};
            if (dump_req) begin
                clear_r <= dump_clear;
            end else begin
                clear_r <= clear_r;
            end
        end else if (handshake_s) begin
            if (last_word_s) begin
                word_idx_r <= {WORD_W{1'b0}};
            end else begin
                word_idx_r <= word_idx_r + WORD_W'(1);
            end
        end else begin
            word_idx_r <= word_idx_r;
        end
    end

    // Sticky bitmap and covered count; a clearing dump restarts them from this cycle's hits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bitmap_r    <= {NUM_POINTS{1'b0}};
            count_r     <= {COUNT_W{1'b0}};
            new_cover_r <= 1'b0;
        end else if (final_hs_s && clear_r) begin
            bitmap_r    <= hit_mask_s;
            count_r     <= popcount(hit_mask_s);
            new_cover_r <= |new_bits_s;
        end else begin
            bitmap_r    <= bitmap_r | hit_mask_s;
            count_r     <= count_r + popcount(new_bits_s);
            new_cover_r <= |new_bits_s;
        end
    end

    // Zero-pad the bitmap to a whole number of 32-bit words.
    always_comb begin
        padded_s                 = {(NUM_WORDS*32){1'b0}};
        padded_s[NUM_POINTS-1:0] = bitmap_r;
    end

    // Dump outputs: live bitmap word while dumping, all quiet in IDLE.
    always_comb begin
        if (state_r == DUMP) begin
            dump_data = padded_s[32*int'(word_idx_r) +: 32];
            dump_last = last_word_s;
        end else begin
            dump_data = 32'd0;
            dump_last = 1'b0;
        end
    end

    assign dump_valid    = (state_r == DUMP);
    assign busy          = (state_r == DUMP);
    assign covered_count = count_r;
    assign new_cover     = new_cover_r;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Self-checking bench for cover_toggle_collector (NUM_POINTS=64, HIT_W=4).
// The reference model is a plain 64-bit set of covered points.
module tb_cover_toggle_collector;

    localparam int NP = 64;
    localparam int HW = 4;
    localparam int IW = 16;
    localparam int CW = 7;

    logic          clock = 1'b0;
    logic          reset;
    logic          hit_valid;
    logic [IW-1:0] hit_base;
    logic [HW-1:0] hit_bits;
    logic          dump_req;
    logic          dump_clear;
    logic          dump_valid;
    logic          dump_ready;
    logic [31:0]   dump_data;
    logic          dump_last;
    logic          busy;
    logic [CW-1:0] covered_count;
    logic          new_cover;

    int checks = 0;
    int errors = 0;
    logic [63:0] m_map;

    cover_toggle_collector #(.NUM_POINTS(NP), .HIT_W(HW), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset),
        .hit_valid(hit_valid), .hit_base(hit_base), .hit_bits(hit_bits),
        .dump_req(dump_req), .dump_clear(dump_clear),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last), .busy(busy),
        .covered_count(covered_count), .new_cover(new_cover)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_hit(input bit v, input int base, input logic [3:0] bits);
        hit_valid = v;
        hit_base  = IW'(base);
        hit_bits  = bits;
    endtask

    // Set of points a beat names, restricted to the tracked range.
    function automatic logic [63:0] beat_points(input bit v, input int base, input logic [3:0] bits);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < 4; i++) begin
            if (v && bits[i] && (base + i) < NP) m[base + i] = 1'b1;
        end
        return m;
    endfunction

    // One hit beat outside a dump, checking count and new_cover afterwards.
    task automatic hit_step(input string tag, input bit v, input int base, input logic [3:0] bits);
        logic [63:0] pts;
        logic        fresh;
        pts   = beat_points(v, base, bits);
        fresh = |(pts & ~m_map);
        drive_hit(v, base, bits);
        tick();
        m_map = m_map | pts;
        check({tag, "_count"}, 64'(covered_count), 64'($countones(m_map)));
        check({tag, "_new"}, 64'(new_cover), 64'(fresh));
    endtask

    task automatic do_dump(input bit clr, input bit rnd_ready, input bit rnd_hits,
                           input bit fin_hit, input int fin_base, input logic [3:0] fin_bits,
                           input int exp_busy);
        int          w;
        int          cyc;
        int          busy_cnt;
        bit          rdy;
        bit          fin;
        bit          hv;
        int          hb;
        logic [3:0]  hbits;
        logic [63:0] pts;
        logic        fresh;
        w = 0; cyc = 0; busy_cnt = 0;
        drive_hit(0, 0, 4'd0);
        dump_req = 1'b1;
        dump_clear = clr;
        tick();
        m_map = m_map;
        dump_req = 1'b0;
        dump_clear = 1'b0;
        while (w < 2 && cyc < 200) begin
            check("dump_valid", 64'(dump_valid), 64'd1);
            check("dump_busy", 64'(busy), 64'd1);
            check("dump_data", 64'(dump_data), 64'(m_map[w*32 +: 32]));
            check("dump_last", 64'(dump_last), 64'(w == 1));
            busy_cnt++;
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            fin = rdy && (w == 1);
            if (fin && fin_hit) begin
                hv = 1'b1; hb = fin_base; hbits = fin_bits;
            end else if (rnd_hits) begin
                hv = 1'($urandom_range(0, 1)); hb = $urandom_range(0, 70); hbits = 4'($urandom);
            end else begin
                hv = 1'b0; hb = 0; hbits = 4'd0;
            end
            pts = beat_points(hv, hb, hbits);
            fresh = |(pts & ~m_map);
            drive_hit(hv, hb, hbits);
            dump_ready = rdy;
            tick();
            if (fin && clr) begin
                m_map = pts;
            end else begin
                m_map = m_map | pts;
                check("dump_new", 64'(new_cover), 64'(fresh));
            end
            check("dump_count", 64'(covered_count), 64'($countones(m_map)));
            if (rdy) w++;
            cyc++;
        end
        dump_ready = 1'b0;
        drive_hit(0, 0, 4'd0);
        check("dump_words", 64'(w), 64'd2);
        check("idle_valid", 64'(dump_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_data", 64'(dump_data), 64'd0);
        check("idle_last", 64'(dump_last), 64'd0);
        if (exp_busy > 0) check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    endtask

    initial begin
        reset = 1'b1;
        dump_req = 1'b0; dump_clear = 1'b0; dump_ready = 1'b0;
        m_map = 64'd0;
        // Hits and requests while reset is held must be ignored.
        drive_hit(1, 0, 4'hF);
        dump_req = 1'b1;
        tick();
        tick();
        check("rst_count", 64'(covered_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(dump_valid), 64'd0);
        check("rst_new", 64'(new_cover), 64'd0);
        drive_hit(0, 0, 4'd0);
        dump_req = 1'b0;
        reset = 1'b0;
        tick();
        check("post_rst_count", 64'(covered_count), 64'd0);

        // Basic hits and re-hits.
        hit_step("h1011", 1, 0, 4'b1011);
        check("h1011_abs", 64'(covered_count), 64'd3);
        hit_step("h1011_rep", 1, 0, 4'b1011);
        check("h1011_rep_new", 64'(new_cover), 64'd0);
        hit_step("invalid", 0, 8, 4'b1111);
        // Upper boundary: only 62 and 63 exist.
        hit_step("edge62", 1, 62, 4'b1111);
        check("edge62_abs", 64'(covered_count), 64'd5);
        hit_step("beyond", 1, 64, 4'b1111);
        hit_step("far", 1, 65000, 4'b1111);

        // Clearing dump, then the two-word example with ready held high.
        do_dump(1, 0, 0, 0, 0, 4'd0, 2);
        check("cleared_count", 64'(covered_count), 64'd0);
        hit_step("p0", 1, 0, 4'b0001);
        hit_step("p33", 1, 33, 4'b0001);
        check("two_word_map", m_map, 64'h0000_0002_0000_0001);
        do_dump(0, 0, 0, 0, 0, 4'd0, 2);

        // Ready toggling randomly: words held until accepted.
        for (int k = 0; k < 3; k++) do_dump(0, 1, 0, 0, 0, 4'd0, 0);

        // Clear with a hit in the final handshake cycle.
        hit_step("pre_clr", 1, 40, 4'b1111);
        do_dump(1, 0, 0, 1, 5, 4'b0001, 2);
        check("clr_survivor_count", 64'(covered_count), 64'd1);
        check("clr_survivor_map", m_map, 64'h20);
        do_dump(0, 0, 0, 0, 0, 4'd0, 2);

        // Random hits mixed with random dumps.
        for (int r = 0; r < 300; r++) begin
            hit_step("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, 70), 4'($urandom));
            if ((r % 60) == 59) do_dump(1'($urandom_range(0, 1)), 1, 1, 0, 0, 4'd0, 0);
        end

        // Reset in the middle of a dump.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        dump_ready = 1'b0;
        tick();
        check("mid_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        m_map = 64'd0;
        check("abort_valid", 64'(dump_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_count", 64'(covered_count), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        do_dump(0, 0, 0, 0, 0, 4'd0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
